// File: rtl/turn_signal_seq.sv
// Parametrised tail-light sequencer: outward left/right sweeps, hazard flashing
// and a brake overlay across LIGHTS_PER_SIDE lights per side.
module turn_signal_seq #(
  parameter int LIGHTS_PER_SIDE = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [3:0]                     stimulus,
  input  logic                           brake,
  output logic [2*LIGHTS_PER_SIDE-1:0]   response
);

  localparam int N  = LIGHTS_PER_SIDE;
  localparam int PW = $clog2(N + 1);
  localparam logic [PW-1:0] PHASE_MAX  = PW'(N);
  localparam logic [PW-1:0] PHASE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } mode_t;

  mode_t         mode_r, mode_nx_s;
  logic [PW-1:0] phase_r, phase_nx_s;
  logic          clear_s, hazard_s, left_s, right_s;

  // Light pattern for a mode/phase; the side not sweeping goes fully on under brake.
  function automatic logic [2*N-1:0] lights(input mode_t m, input logic [PW-1:0] k,
                                            input logic brk);
    logic [N-1:0] lh;
    logic [N-1:0] rh;
    lh = {N{1'b0}};
    rh = {N{1'b0}};
    case (m)
      LEFT: begin
        for (int i = 0; i < N; i++) lh[i] = (i < int'(k));
        rh = brk ? {N{1'b1}} : {N{1'b0}};
      end
      RIGHT: begin
        for (int i = 0; i < N; i++) rh[N-1-i] = (i < int'(k));
        lh = brk ? {N{1'b1}} : {N{1'b0}};
      end
      IDLE: begin
        lh = brk ? {N{1'b1}} : {N{1'b0}};
        rh = brk ? {N{1'b1}} : {N{1'b0}};
      end
      HAZ_ON: begin
        lh = {N{1'b1}};
        rh = {N{1'b1}};
      end
      default: begin
        lh = {N{1'b0}};
        rh = {N{1'b0}};
      end
    endcase
    return {lh, rh};
  endfunction

  // Decode the active-low button bus into one prioritised request.
  always_comb begin
    clear_s  = ~stimulus[1];
    hazard_s = ~clear_s & (~stimulus[2] | (~stimulus[3] & ~stimulus[0]));
    left_s   = ~clear_s & ~hazard_s & ~stimulus[3];
    right_s  = ~clear_s & ~hazard_s & ~left_s & ~stimulus[0];
  end

  // Next mode/phase; clear bypasses the enable qualifier.
  always_comb begin
    mode_nx_s  = mode_r;
    phase_nx_s = phase_r;
    if (clear_s) begin
      mode_nx_s  = IDLE;
      phase_nx_s = PHASE_ZERO;
    end else if (enable) begin
      case (mode_r)
        IDLE: begin
          if (hazard_s) begin
            mode_nx_s  = HAZ_ON;
            phase_nx_s = PHASE_ZERO;
          end else if (left_s) begin
            mode_nx_s  = LEFT;
            phase_nx_s = PHASE_ONE;
          end else if (right_s) begin
            mode_nx_s  = RIGHT;
            phase_nx_s = PHASE_ONE;
          end else begin
            mode_nx_s  = IDLE;
            phase_nx_s = PHASE_ZERO;
          end
        end
        LEFT, RIGHT: begin
          // A started sweep runs to completion unless hazard pre-empts it.
          if (hazard_s) begin
            mode_nx_s  = HAZ_ON;
            phase_nx_s = PHASE_ZERO;
          end else if (phase_r < PHASE_MAX) begin
            mode_nx_s  = mode_r;
            phase_nx_s = phase_r + PHASE_ONE;
          end else begin
            mode_nx_s  = IDLE;
            phase_nx_s = PHASE_ZERO;
          end
        end
        HAZ_ON: begin
          mode_nx_s  = hazard_s ? HAZ_OFF : IDLE;
          phase_nx_s = PHASE_ZERO;
        end
        HAZ_OFF: begin
          mode_nx_s  = hazard_s ? HAZ_ON : IDLE;
          phase_nx_s = PHASE_ZERO;
        end
        default: begin
          mode_nx_s  = IDLE;
          phase_nx_s = PHASE_ZERO;
        end
      endcase
    end else begin
      mode_nx_s  = mode_r;
      phase_nx_s = phase_r;
    end
  end

  // State and registered light drive, built from the next state and current brake.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_r   <= IDLE;
      phase_r  <= PHASE_ZERO;
      response <= {(2*N){1'b0}};
    end else begin
      mode_r   <= mode_nx_s;
      phase_r  <= phase_nx_s;
      response <= lights(mode_nx_s, phase_nx_s, brake);
    end
  end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed bench for turn_signal_seq: vector table for N=3, hand sequences
// for sweep periods and clear with N=1 and N=5.
module tb_turn_signal_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] stimulus;
  logic       brake;
  logic [5:0] resp3;
  logic [1:0] resp1;
  logic [9:0] resp5;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  turn_signal_seq #(.LIGHTS_PER_SIDE(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable),
    .stimulus(stimulus), .brake(brake), .response(resp3));

  turn_signal_seq #(.LIGHTS_PER_SIDE(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable),
    .stimulus(stimulus), .brake(brake), .response(resp1));

  turn_signal_seq #(.LIGHTS_PER_SIDE(5)) dut5 (
    .clock(clock), .reset(reset), .enable(enable),
    .stimulus(stimulus), .brake(brake), .response(resp5));

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] stim;
    logic       brk;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic [3:0] stim,
                     input logic brk, input logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.en = en; v.stim = stim; v.brk = brk; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [9:0] e5;
    logic [4:0] t;
    int p;

    reset = 1'b1; enable = 1'b1; stimulus = 4'b1111; brake = 1'b0;

    // reset and idle
    add(1'b1, 1'b1, 4'b0111, 1'b1, 6'b000000);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // left sweep, held
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b011000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b111000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b001000);
    // enable low freezes LEFT(1)
    add(1'b0, 1'b0, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b0, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b0, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b0, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b011000);
    // release left at LEFT(2): sweep completes
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b111000);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // right sweep
    add(1'b0, 1'b1, 4'b1110, 1'b0, 6'b000100);
    add(1'b0, 1'b1, 4'b1110, 1'b0, 6'b000110);
    add(1'b0, 1'b1, 4'b1110, 1'b0, 6'b000111);
    add(1'b0, 1'b1, 4'b1110, 1'b0, 6'b000000);
    // hazard via hazard_n
    add(1'b0, 1'b1, 4'b1011, 1'b0, 6'b111111);
    add(1'b0, 1'b1, 4'b1011, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b1011, 1'b0, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // hazard via left+right
    add(1'b0, 1'b1, 4'b0110, 1'b0, 6'b111111);
    add(1'b0, 1'b1, 4'b0110, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b0110, 1'b0, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // hazard pre-empts a sweep at LEFT(2)
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b011000);
    add(1'b0, 1'b1, 4'b1011, 1'b0, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // brake during right sweep, then idle with brake
    add(1'b0, 1'b1, 4'b1110, 1'b1, 6'b111100);
    add(1'b0, 1'b1, 4'b1110, 1'b1, 6'b111110);
    add(1'b0, 1'b1, 4'b1110, 1'b1, 6'b111111);
    add(1'b0, 1'b1, 4'b1110, 1'b1, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b1, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // brake in idle: one clock latency
    add(1'b0, 1'b1, 4'b1111, 1'b1, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // brake ignored during hazard
    add(1'b0, 1'b1, 4'b1011, 1'b1, 6'b111111);
    add(1'b0, 1'b1, 4'b1011, 1'b1, 6'b000000);
    add(1'b0, 1'b1, 4'b1011, 1'b1, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // brake during left sweep
    add(1'b0, 1'b1, 4'b0111, 1'b1, 6'b001111);
    add(1'b0, 1'b1, 4'b0111, 1'b1, 6'b011111);
    add(1'b0, 1'b1, 4'b1111, 1'b1, 6'b111111);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    // brake acts with enable low
    add(1'b0, 1'b0, 4'b1111, 1'b1, 6'b111111);
    add(1'b0, 1'b0, 4'b1111, 1'b0, 6'b000000);
    // clear at LEFT(2) with enable low, clear beats hazard
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b011000);
    add(1'b0, 1'b0, 4'b1101, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b1001, 1'b0, 6'b000000);
    // reset mid-sweep aborts; reset beats hazard and brake
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b001000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b011000);
    add(1'b1, 1'b1, 4'b0111, 1'b0, 6'b000000);
    add(1'b0, 1'b1, 4'b0111, 1'b0, 6'b001000);
    add(1'b1, 1'b1, 4'b1011, 1'b1, 6'b000000);
    add(1'b0, 1'b1, 4'b1111, 1'b0, 6'b000000);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; enable = vecs[i].en;
      stimulus = vecs[i].stim; brake = vecs[i].brk;
      step();
      check($sformatf("n3_vec%0d", i), {4'b0000, resp3}, {4'b0000, vecs[i].exp});
    end

    // N=1 and N=5: sweep periods of 2 and 6 steps
    reset = 1'b1; enable = 1'b1; stimulus = 4'b1111; brake = 1'b0;
    step();
    check("n1_reset", {8'b0, resp1}, 10'b0);
    check("n5_reset", resp5, 10'b0);
    reset = 1'b0; stimulus = 4'b0111;
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("n1_left%0d", j), {8'b0, resp1}, (j % 2 == 1) ? 10'b0000000010 : 10'b0);
      p = (j - 1) % 6;
      e5 = (p < 5) ? (10'((1 << (p + 1)) - 1) << 5) : 10'b0;
      check($sformatf("n5_left%0d", j), resp5, e5);
    end
    step();
    step();
    check("n5_left2_again", resp5, 10'b0001100000);
    enable = 1'b0; stimulus = 4'b1101;
    step();
    check("n5_clear_en0", resp5, 10'b0);
    check("n1_clear_en0", {8'b0, resp1}, 10'b0);

    enable = 1'b1; stimulus = 4'b1011;
    step();
    check("n5_haz_on", resp5, 10'b1111111111);
    check("n1_haz_on", {8'b0, resp1}, 10'b0000000011);
    step();
    check("n5_haz_off", resp5, 10'b0);
    stimulus = 4'b1111;
    step();
    check("n5_haz_release", resp5, 10'b0);

    stimulus = 4'b1110;
    for (int k = 1; k <= 6; k++) begin
      step();
      t = 5'b11111;
      t = (k <= 5) ? (t << (5 - k)) : 5'b00000;
      check($sformatf("n5_right%0d", k), resp5, {5'b00000, t});
      check($sformatf("n1_right%0d", k), {8'b0, resp1}, (k % 2 == 1) ? 10'b0000000001 : 10'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
